fp_interrupt_controller: RTL and testbench
==========================================

FP_INTERRUPT_CONTROLLER -- requirements
Module: fp_interrupt_controller

Interface
REQ-001 The block SHALL have no parameters; the exception count (6) and cause width (3) SHALL be package constants.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 interrupt_reset_n  input  1  asynchronous, active-low reset.
REQ-004 fpu_valid  input  1  FPU operation completes this cycle; exc_flags is qualified by it.
REQ-005 exc_flags  input  6  bit 5 SNaN, 4 div_by_zero, 3 overflow, 2 underflow, 1 QNaN, 0 inexact.
REQ-006 mask_we  input  1  write strobe for the enable register.
REQ-007 mask_wdata  input  6  enable value, same bit order as exc_flags; 1 = interrupt enabled.
REQ-008 status_clr  input  1  clears all sticky status bits.
REQ-009 irq_ack  input  1  sequencer accepts the presented interrupt.
REQ-010 irq_done  input  1  sequencer handler return.
REQ-011 irq  output  1  interrupt request to the sequencer, registered.
REQ-012 irq_cause  output  3  cause code: bit index + 1; 0 = none; registered.
REQ-013 pending  output  6  per-exception pending register.
REQ-014 sticky_status  output  6  accumulated exception flags, independent of mask.
REQ-015 enable  output  6  current enable register.
REQ-016 in_service  output  1  high while in state SERVICE.

Function
REQ-017 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-018 A rising edge with fpu_valid=1 SHALL OR exc_flags into pending and into sticky_status.
REQ-019 Priority, highest first: SNaN, div_by_zero, overflow, underflow, QNaN, inexact.
REQ-020 IDLE -> REQ when (pending & enable) != 0 at a rising edge; on that edge irq<=1 and irq_cause<=highest-priority enabled pending code.
REQ-021 Latency: flag captured at edge E1, irq high after edge E2; minimum 2 cycles from fpu_valid to irq.
REQ-022 In REQ, irq_cause SHALL be held; a newly pending higher-priority exception SHALL NOT preempt it.
REQ-023 REQ -> SERVICE on irq_ack=1: irq<=0, irq_cause<=0, the presented cause's pending bit cleared.
REQ-024 REQ -> IDLE if the presented cause becomes disabled by a mask write: irq<=0, irq_cause<=0, pending unchanged.
REQ-025 SERVICE -> IDLE on irq_done=1; no nesting; events during SERVICE only accumulate in pending.
REQ-026 irq_ack outside REQ and irq_done outside SERVICE SHALL be ignored.
REQ-027 A set from fpu_valid SHALL win over a clear by irq_ack on the same bit in the same cycle.
REQ-028 A set from fpu_valid SHALL win over status_clr on the same bit in the same cycle.
REQ-029 Disabled exceptions SHALL still set pending; a later mask write enabling them SHALL raise irq per REQ-020.
REQ-030 A mask write takes effect on the edge it is sampled; arbitration uses the new value from the next cycle.

Reset
REQ-031 Reset asserted SHALL immediately force state IDLE, irq=0, irq_cause=0, pending=0, sticky_status=0, enable=6'b111111, in_service=0.
REQ-032 Reset asserted mid-REQ or mid-SERVICE SHALL drop irq and in_service without waiting for the clock.
REQ-033 Reset deassertion SHALL be consumed at the next rising edge; inputs are ignored while reset is asserted.

Structure
REQ-034 A shared package fp_exc_pkg SHALL hold the exception bit indices, NUM_EXC=6, CAUSE_W=3, cause code constants and the FSM state type.
REQ-035 The priority encoder SHALL be one combinational sub-module, fp_exc_prio_enc (6-bit vector in, 3-bit cause out).

Verification
REQ-036 Reset, fpu_valid=1 with exc_flags=6'b010000 -> pending=6'b010000, irq=1 and irq_cause=5 two edges later.
REQ-037 exc_flags=6'b100101 in one cycle -> cause 6; ack, done -> cause 3; ack, done -> cause 1; ack, done -> irq stays 0, pending=0.
REQ-038 enable=6'b000000, then overflow -> irq=0 and sticky_status[3]=1; mask_wdata=6'b001000 -> irq=1 and cause=4.
REQ-039 SNaN in REQ with cause=2 presented -> cause stays 2 until ack; after irq_done, cause=6.
REQ-040 irq_ack and fpu_valid with the same flag in one cycle -> pending bit stays 1; status_clr with a flag set -> that sticky bit stays 1.
REQ-041 Reset asserted in SERVICE between edges -> irq=0, in_service=0 and pending=0 immediately; enable=6'b111111.

Source files
------------

// File: rtl/fp_exc_pkg.sv
// Shared constants and types for the floating-point exception interrupt controller.
// Contents: exception bit indices, vector/cause widths, cause codes,
// the controller FSM state type, and a helper that converts a cause code
// back into its one-hot exception bit.
package fp_exc_pkg;

  localparam int NUM_EXC = 6;
  localparam int CAUSE_W = 3;

  // Bit positions inside exc_flags / enable / pending / sticky_status
  localparam int EXC_INEXACT   = 0;
  localparam int EXC_QNAN      = 1;
  localparam int EXC_UNDERFLOW = 2;
  localparam int EXC_OVERFLOW  = 3;
  localparam int EXC_DIV0      = 4;
  localparam int EXC_SNAN      = 5;

  // Cause code = bit index + 1, so that 0 can mean "no interrupt"
  localparam logic [CAUSE_W-1:0] CAUSE_NONE      = 3'd0;
  localparam logic [CAUSE_W-1:0] CAUSE_INEXACT   = 3'd1;
  localparam logic [CAUSE_W-1:0] CAUSE_QNAN      = 3'd2;
  localparam logic [CAUSE_W-1:0] CAUSE_UNDERFLOW = 3'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_OVERFLOW  = 3'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_DIV0      = 3'd5;
  localparam logic [CAUSE_W-1:0] CAUSE_SNAN      = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } fsm_state_t;

  // One-hot exception bit for a cause code; all-zero for CAUSE_NONE or
  // out-of-range codes.
  function automatic logic [NUM_EXC-1:0] cause_to_mask(input logic [CAUSE_W-1:0] c);
    logic [NUM_EXC-1:0] m;
    for (int i = 0; i < NUM_EXC; i++) begin
      m[i] = (c == CAUSE_W'(i + 1));
    end
    return m;
  endfunction

endpackage

// File: rtl/fp_interrupt_controller_if.sv
// Bus between the FPU/sequencer side and the interrupt controller.
// master : drives fpu_valid, exc_flags, mask_we, mask_wdata, status_clr,
//          irq_ack, irq_done; observes irq, irq_cause, pending,
//          sticky_status, enable, in_service.
// slave  : the controller (opposite directions).
interface fp_interrupt_controller_if;
  import fp_exc_pkg::*;

  logic               fpu_valid;
  logic [NUM_EXC-1:0] exc_flags;
  logic               mask_we;
  logic [NUM_EXC-1:0] mask_wdata;
  logic               status_clr;
  logic               irq_ack;
  logic               irq_done;
  logic               irq;
  logic [CAUSE_W-1:0] irq_cause;
  logic [NUM_EXC-1:0] pending;
  logic [NUM_EXC-1:0] sticky_status;
  logic [NUM_EXC-1:0] enable;
  logic               in_service;

  modport master (
    output fpu_valid, exc_flags, mask_we, mask_wdata, status_clr, irq_ack, irq_done,
    input  irq, irq_cause, pending, sticky_status, enable, in_service
  );

  modport slave (
    input  fpu_valid, exc_flags, mask_we, mask_wdata, status_clr, irq_ack, irq_done,
    output irq, irq_cause, pending, sticky_status, enable, in_service
  );

endinterface

// File: rtl/fp_exc_prio_enc.sv
// Fixed-priority encoder for pending-and-enabled exceptions.
// Ports:
//   vec   in  NUM_EXC  candidate exceptions (bit order as exc_flags)
//   cause out CAUSE_W  highest-priority set bit as index+1, 0 if none
// Priority follows bit index: SNaN (bit 5) highest, inexact (bit 0) lowest.
module fp_exc_prio_enc
  import fp_exc_pkg::*;
(
  input  logic [NUM_EXC-1:0] vec,
  output logic [CAUSE_W-1:0] cause
);

  // Ascending scan: the last (highest) set bit overwrites lower ones.
  always_comb begin
    cause = CAUSE_NONE;
    for (int i = 0; i < NUM_EXC; i++) begin
      if (vec[i]) cause = CAUSE_W'(i + 1);
    end
  end

endmodule

// File: rtl/fp_interrupt_controller.sv
// Floating-point exception interrupt controller.
// Captures FPU exception flags into pending and sticky registers, arbitrates
// enabled pending exceptions by fixed priority and hands one interrupt at a
// time to the sequencer through an ack/done handshake.
// Ports:
//   clk               in   rising-edge clock
//   interrupt_reset_n in   asynchronous active-low reset
//   bus               slave modport of fp_interrupt_controller_if
//
// state      | meaning
// -----------+-------------------------------------------------------
// ST_IDLE    | no interrupt presented; arbitrating pending & enable
// ST_REQ     | irq high, irq_cause held until ack or mask-out
// ST_SERVICE | handler running; new events only accumulate in pending
module fp_interrupt_controller
  import fp_exc_pkg::*;
(
  input logic                      clk,
  input logic                      interrupt_reset_n,
  fp_interrupt_controller_if.slave bus
);

  fsm_state_t         state_q, state_d;
  logic               irq_q, irq_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic [NUM_EXC-1:0] pending_q, pending_d;
  logic [NUM_EXC-1:0] sticky_q, sticky_d;
  logic [NUM_EXC-1:0] enable_q, enable_d;

  logic [NUM_EXC-1:0] req_vec;
  logic [CAUSE_W-1:0] arb_cause;
  logic [NUM_EXC-1:0] set_vec;
  logic [NUM_EXC-1:0] clr_mask;
  logic               cause_masked;

  assign req_vec = pending_q & enable_q;
  assign set_vec = bus.fpu_valid ? bus.exc_flags : '0;

  // The presented cause is withdrawn when the mask write sampled this edge
  // disables it.
  assign cause_masked = bus.mask_we && ((bus.mask_wdata & cause_to_mask(cause_q)) == '0);

  fp_exc_prio_enc u_prio_enc (
    .vec   (req_vec),
    .cause (arb_cause)
  );

  // State and register update
  always_ff @(posedge clk or negedge interrupt_reset_n) begin
    if (!interrupt_reset_n) begin
      state_q   <= ST_IDLE;
      irq_q     <= 1'b0;
      cause_q   <= CAUSE_NONE;
      pending_q <= '0;
      sticky_q  <= '0;
      enable_q  <= '1;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_d;
      cause_q   <= cause_d;
      pending_q <= pending_d;
      sticky_q  <= sticky_d;
      enable_q  <= enable_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (|req_vec) state_d = ST_REQ;
      ST_REQ: begin
        if (bus.irq_ack)      state_d = ST_SERVICE;
        else if (cause_masked) state_d = ST_IDLE;
      end
      ST_SERVICE: if (bus.irq_done) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and the pending clear on acknowledge
  always_comb begin
    irq_d    = irq_q;
    cause_d  = cause_q;
    clr_mask = '0;
    case (state_q)
      ST_IDLE: begin
        if (|req_vec) begin
          irq_d   = 1'b1;
          cause_d = arb_cause;
        end
      end
      ST_REQ: begin
        if (bus.irq_ack) begin
          irq_d    = 1'b0;
          cause_d  = CAUSE_NONE;
          clr_mask = cause_to_mask(cause_q);
        end else if (cause_masked) begin
          irq_d   = 1'b0;
          cause_d = CAUSE_NONE;
        end
      end
      default: begin
        irq_d   = 1'b0;
        cause_d = CAUSE_NONE;
      end
    endcase
  end

  // Sets are ORed in after clears so a same-cycle event always survives.
  always_comb begin
    pending_d = (pending_q & ~clr_mask) | set_vec;
    sticky_d  = (bus.status_clr ? '0 : sticky_q) | set_vec;
    enable_d  = bus.mask_we ? bus.mask_wdata : enable_q;
  end

  assign bus.irq           = irq_q;
  assign bus.irq_cause     = cause_q;
  assign bus.pending       = pending_q;
  assign bus.sticky_status = sticky_q;
  assign bus.enable        = enable_q;
  assign bus.in_service    = (state_q == ST_SERVICE);

endmodule

// File: tb/tb_fp_interrupt_controller.sv
// Scoreboard bench for fp_interrupt_controller: a driver issues one cycle of
// stimulus at each falling edge, advances a behavioural model and queues the
// expected post-edge outputs; a monitor pops and compares after each rising edge.
module tb_fp_interrupt_controller;
  import fp_exc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_interrupt_controller_if bus();

  fp_interrupt_controller dut (
    .clk               (clk),
    .interrupt_reset_n (rst_n),
    .bus               (bus)
  );

  typedef struct {
    bit       irq;
    int       cause;
    bit [5:0] pend;
    bit [5:0] sticky;
    bit [5:0] en;
    bit       insvc;
  } exp_t;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  // Model: mode 0 = nothing presented, 1 = interrupt presented, 2 = handler running
  int       m_mode;
  int       m_cause;
  bit [5:0] m_pend, m_sticky, m_en;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int highest(input bit [5:0] v);
    for (int i = 5; i >= 0; i--) if (v[i]) return i + 1;
    return 0;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_cause = 0; m_pend = '0; m_sticky = '0; m_en = 6'h3f;
  endfunction

  task automatic drive_idle();
    bus.fpu_valid = 0; bus.exc_flags = '0; bus.mask_we = 0; bus.mask_wdata = '0;
    bus.status_clr = 0; bus.irq_ack = 0; bus.irq_done = 0;
  endtask

  // One clock of stimulus; the expectation is for the following rising edge.
  task automatic cyc(input bit v, input bit [5:0] f, input bit mwe, input bit [5:0] mwd,
                     input bit sc, input bit ack, input bit done);
    bit [5:0] set;
    exp_t e;
    @(negedge clk);
    bus.fpu_valid = v; bus.exc_flags = f; bus.mask_we = mwe; bus.mask_wdata = mwd;
    bus.status_clr = sc; bus.irq_ack = ack; bus.irq_done = done;
    set = v ? f : 6'h00;
    case (m_mode)
      0: if ((m_pend & m_en) != 0) begin
           m_mode = 1; m_cause = highest(m_pend & m_en);
         end
      1: if (ack) begin
           m_pend[m_cause-1] = 1'b0; m_mode = 2; m_cause = 0;
         end else if (mwe && !mwd[m_cause-1]) begin
           m_mode = 0; m_cause = 0;
         end
      default: if (done) m_mode = 0;
    endcase
    m_pend   = m_pend | set;
    m_sticky = (sc ? 6'h00 : m_sticky) | set;
    if (mwe) m_en = mwd;
    e.irq = (m_mode == 1); e.cause = m_cause; e.pend = m_pend;
    e.sticky = m_sticky; e.en = m_en; e.insvc = (m_mode == 2);
    sb.push_back(e);
  endtask

  task automatic idle();
    cyc(0, 6'h00, 0, 6'h00, 0, 0, 0);
  endtask

  // Moves to just after the rising edge that applies the last cyc() call.
  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_irq"},     int'(bus.irq), 0);
    check({tag, "_cause"},   int'(bus.irq_cause), 0);
    check({tag, "_pending"}, int'(bus.pending), 0);
    check({tag, "_sticky"},  int'(bus.sticky_status), 0);
    check({tag, "_enable"},  int'(bus.enable), 'h3f);
    check({tag, "_insvc"},   int'(bus.in_service), 0);
  endtask

  // Asserts reset between clock edges and checks the outputs respond at once.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #3;
    drive_idle();
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_irq",     int'(bus.irq), int'(e.irq));
        check("sb_cause",   int'(bus.irq_cause), e.cause);
        check("sb_pending", int'(bus.pending), int'(e.pend));
        check("sb_sticky",  int'(bus.sticky_status), int'(e.sticky));
        check("sb_enable",  int'(bus.enable), int'(e.en));
        check("sb_insvc",   int'(bus.in_service), int'(e.insvc));
      end
    end
  end

  // Driver
  initial begin
    drive_idle();
    model_reset();
    // Inputs are ignored while reset is held
    bus.fpu_valid = 1; bus.exc_flags = 6'h3f; bus.mask_we = 1; bus.mask_wdata = 6'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_values("por");
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Single div_by_zero: irq two edges after the flag
    cyc(1, 6'b010000, 0, 6'h00, 0, 0, 0);
    idle();
    settle();
    check("d0_irq", int'(bus.irq), 1);
    check("d0_cause", int'(bus.irq_cause), 5);
    check("d0_pending", int'(bus.pending), 'b010000);
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(0, 6'h00, 0, 6'h00, 0, 0, 1);
    idle();

    // Three simultaneous flags served in priority order
    cyc(1, 6'b100101, 0, 6'h00, 0, 0, 0);
    idle();
    settle();
    check("d1_cause_a", int'(bus.irq_cause), 6);
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(0, 6'h00, 0, 6'h00, 0, 0, 1);
    idle();
    settle();
    check("d1_cause_b", int'(bus.irq_cause), 3);
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(0, 6'h00, 0, 6'h00, 0, 0, 1);
    idle();
    settle();
    check("d1_cause_c", int'(bus.irq_cause), 1);
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(0, 6'h00, 0, 6'h00, 0, 0, 1);
    idle();
    idle();
    settle();
    check("d1_irq_end", int'(bus.irq), 0);
    check("d1_pend_end", int'(bus.pending), 0);

    // Masked overflow, then enabled by a mask write
    cyc(0, 6'h00, 1, 6'h00, 0, 0, 0);
    cyc(1, 6'b001000, 0, 6'h00, 0, 0, 0);
    idle();
    idle();
    settle();
    check("d2_irq_masked", int'(bus.irq), 0);
    check("d2_sticky3", int'(bus.sticky_status[3]), 1);
    cyc(0, 6'h00, 1, 6'b001000, 0, 0, 0);
    idle();
    settle();
    check("d2_irq_unmasked", int'(bus.irq), 1);
    check("d2_cause", int'(bus.irq_cause), 4);
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(0, 6'h00, 1, 6'h3f, 0, 0, 1);

    // No preemption of a presented QNaN by a later SNaN
    cyc(1, 6'b000010, 0, 6'h00, 0, 0, 0);
    idle();
    cyc(1, 6'b100000, 0, 6'h00, 0, 0, 0);
    idle();
    settle();
    check("d3_held_cause", int'(bus.irq_cause), 2);
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(0, 6'h00, 0, 6'h00, 0, 0, 1);
    idle();
    settle();
    check("d3_next_cause", int'(bus.irq_cause), 6);
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(0, 6'h00, 0, 6'h00, 0, 0, 1);

    // Set beats ack clear, set beats status_clr
    cyc(1, 6'b000001, 0, 6'h00, 0, 0, 0);
    idle();
    cyc(1, 6'b000001, 0, 6'h00, 0, 1, 0);
    settle();
    check("d4_pend_kept", int'(bus.pending[0]), 1);
    cyc(0, 6'h00, 0, 6'h00, 0, 0, 1);
    idle();
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(1, 6'b000100, 0, 6'h00, 1, 0, 1);
    settle();
    check("d4_sticky_kept", int'(bus.sticky_status), 'b000100);

    // Reset in the middle of SERVICE with something pending
    idle();
    cyc(0, 6'h00, 0, 6'h00, 0, 1, 0);
    cyc(1, 6'b010000, 0, 6'h00, 0, 0, 0);
    settle();
    check("d5_pre_insvc", int'(bus.in_service), 1);
    do_reset("svc_rst");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      bit v, mwe, sc, ack, done;
      bit [5:0] f, mwd;
      v    = ($urandom_range(0, 99) < 30);
      f    = 6'($urandom) & 6'($urandom);
      mwe  = ($urandom_range(0, 99) < 6);
      mwd  = 6'($urandom);
      sc   = ($urandom_range(0, 99) < 5);
      ack  = ($urandom_range(0, 99) < 35);
      done = ($urandom_range(0, 99) < 35);
      cyc(v, f, mwe, mwd, sc, ack, done);
      if (i % 1000 == 999) do_reset("rnd_rst");
    end
    idle();
    settle();
    check("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
